// File: rtl/time_setter_if.sv
// time_setter_if: buttons in, BCD time digits, edit status and load strobe out
interface time_setter_if;
  logic btn_mode;
  logic btn_up;
  logic btn_set;
  logic [3:0] hourdec_set;
  logic [3:0] hourone_set;
  logic [3:0] mindec_set;
  logic [3:0] minone_set;
  logic editing;
  logic [1:0] edit_sel;
  logic load;
  modport master (
    output btn_mode, btn_up, btn_set,
    input hourdec_set, hourone_set, mindec_set, minone_set, editing, edit_sel, load
  );
  modport slave (
    input btn_mode, btn_up, btn_set,
    output hourdec_set, hourone_set, mindec_set, minone_set, editing, edit_sel, load
  );
endinterface

// File: rtl/time_setter.sv
// time_setter: debounced button time entry producing BCD HH:MM digits and a load strobe
// Define AUTO_REPEAT_EN to get auto-repeat increments while up is held.
module time_setter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input logic clk,
  input logic rstn,
  time_setter_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, EDIT_HD, EDIT_HO, EDIT_MD, EDIT_MO} state_t;
  state_t state, state_n;
  logic [2:0] raw, s0, s1, db, db_q, ev;
  logic [CW-1:0] cnt [3];
  logic [3:0] hd, ho, md, mo;
  logic editing, load, inc_req, inc;
  logic [1:0] edit_sel;
  assign raw = {bus.btn_set, bus.btn_up, bus.btn_mode};
  assign ev = db & ~db_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      s0 <= '0;
      s1 <= '0;
      db <= '0;
      db_q <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s0 <= raw;
      s1 <= s0;
      db_q <= db;
      for (int i = 0; i < 3; i++)
        if (s1[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          db[i] <= s1[i];
        end else cnt[i] <= cnt[i] + 1'b1;
    end
`ifdef AUTO_REPEAT_EN
  logic [31:0] rep_cnt;
  logic rep_armed, rep_tick;
  assign rep_tick = editing && db[1] && rep_cnt == (rep_armed ? 32'(REPEAT_PERIOD - 1) : 32'(REPEAT_DELAY - 1));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rep_cnt <= '0;
      rep_armed <= 1'b0;
    end else if (!db[1] || !editing || state_n != state || ev[1]) begin
      rep_cnt <= '0;
      rep_armed <= 1'b0;
    end else if (rep_tick) begin
      rep_cnt <= '0;
      rep_armed <= 1'b1;
    end else rep_cnt <= rep_cnt + 1'b1;
  assign inc_req = ev[1] | rep_tick;
`else
  assign inc_req = ev[1];
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state != IDLE && ev[2]) state_n = IDLE;
    else if (ev[0]) state_n = state == EDIT_MO ? IDLE : state_t'(state + 3'd1);
  end
  always_comb begin
    editing = state != IDLE;
    edit_sel = editing ? 2'(3'd4 - state) : 2'd0;
  end
  // set has priority: a commit suppresses any increment in the same cycle
  assign inc = inc_req && editing && !ev[2];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      hd <= '0;
      ho <= '0;
      md <= '0;
      mo <= '0;
      load <= 1'b0;
    end else begin
      load <= editing && ev[2];
      if (inc)
        case (state)
          EDIT_HD: begin
            hd <= hd >= 4'd2 ? 4'd0 : hd + 4'd1;
            if (hd == 4'd1 && ho > 4'd3) ho <= 4'd3;
          end
          EDIT_HO: ho <= ho >= (hd == 4'd2 ? 4'd3 : 4'd9) ? 4'd0 : ho + 4'd1;
          EDIT_MD: md <= md >= 4'd5 ? 4'd0 : md + 4'd1;
          EDIT_MO: mo <= mo >= 4'd9 ? 4'd0 : mo + 4'd1;
          default: ;
        endcase
    end
  assign bus.hourdec_set = hd;
  assign bus.hourone_set = ho;
  assign bus.mindec_set = md;
  assign bus.minone_set = mo;
  assign bus.editing = editing;
  assign bus.edit_sel = edit_sel;
  assign bus.load = load;
endmodule

// File: tb/tb_time_setter.sv
// tb_time_setter: directed and random button presses checked against a digit-level model
module tb_time_setter;
  localparam int DB = 4, RD = 20, RP = 5;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0, errors = 0;
  int m_hd = 0, m_ho = 0, m_md = 0, m_mo = 0, m_sel = -1;
  int load_exp = 0, load_seen = 0, run = 0, max_run = 0;
  time_setter_if bus();
  time_setter #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (bus.load) begin
      load_seen++;
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_all(string tag);
    chk({tag, ".hd"}, int'(bus.hourdec_set), m_hd);
    chk({tag, ".ho"}, int'(bus.hourone_set), m_ho);
    chk({tag, ".md"}, int'(bus.mindec_set), m_md);
    chk({tag, ".mo"}, int'(bus.minone_set), m_mo);
    chk({tag, ".editing"}, int'(bus.editing), m_sel >= 0 ? 1 : 0);
    chk({tag, ".edit_sel"}, int'(bus.edit_sel), m_sel >= 0 ? m_sel : 0);
    chk({tag, ".loads"}, load_seen, load_exp);
  endtask
  task automatic m_inc();
    case (m_sel)
      3: begin m_hd = (m_hd + 1) % 3; if (m_hd == 2 && m_ho > 3) m_ho = 3; end
      2: m_ho = (m_ho + 1) % (m_hd == 2 ? 4 : 10);
      1: m_md = (m_md + 1) % 6;
      0: m_mo = (m_mo + 1) % 10;
      default: ;
    endcase
  endtask
  task automatic m_step(bit m, bit u, bit s, int reps);
    if (s && m_sel >= 0) begin
      m_sel = -1;
      load_exp++;
    end else begin
      if (u && m_sel >= 0) repeat (reps) m_inc();
      if (m) m_sel = m_sel < 0 ? 3 : m_sel - 1;
    end
  endtask
  task automatic press(bit m, bit u, bit s, int hold);
    int reps = 1;
`ifdef AUTO_REPEAT_EN
    for (int t = RD; t < hold; t += RP) reps++;
`endif
    @(posedge clk); #1;
    bus.btn_mode = m; bus.btn_up = u; bus.btn_set = s;
    repeat (hold) @(posedge clk);
    #1;
    bus.btn_mode = 0; bus.btn_up = 0; bus.btn_set = 0;
    repeat (DB + 8) @(posedge clk);
    m_step(m, u, s, reps);
    @(negedge clk);
  endtask
  task automatic do_reset();
    @(posedge clk); #3;
    rstn = 0;
    #1;
    m_hd = 0; m_ho = 0; m_md = 0; m_mo = 0; m_sel = -1;
    check_all("reset_async");
    @(negedge clk);
    rstn = 1;
  endtask
  initial begin
    bus.btn_mode = 0; bus.btn_up = 0; bus.btn_set = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rstn = 1;
    press(1, 0, 0, 10);
    chk("enter_sel", int'(bus.edit_sel), 3);
    press(0, 1, 0, 10); chk("hd_1", int'(bus.hourdec_set), 1);
    press(0, 1, 0, 10); chk("hd_2", int'(bus.hourdec_set), 2);
    press(0, 1, 0, 10); chk("hd_0", int'(bus.hourdec_set), 0);
    press(0, 0, 1, 10);
    check_all("commit1");
    chk("commit1_load", load_seen, 1);
    press(1, 0, 0, 10); press(1, 0, 0, 10);
    repeat (9) press(0, 1, 0, 10);
    chk("ho_9", int'(bus.hourone_set), 9);
    repeat (4) press(1, 0, 0, 10);
    press(0, 1, 0, 10); press(0, 1, 0, 10);
    chk("hd_2b", int'(bus.hourdec_set), 2);
    chk("ho_forced", int'(bus.hourone_set), 3);
    press(1, 0, 0, 10);
    press(0, 1, 0, 10);
    chk("ho_wrap3", int'(bus.hourone_set), 0);
    press(1, 0, 0, 10);
    for (int i = 0; i < 6; i++) begin
      press(0, 1, 0, 10);
      chk("md_seq", int'(bus.mindec_set), (i + 1) % 6);
    end
    press(1, 0, 0, 10);
    repeat (10) press(0, 1, 0, 10);
    check_all("mo_wrap");
    chk("mo_0", int'(bus.minone_set), 0);
    @(posedge clk); #1;
    bus.btn_up = 1;
    repeat (2) @(posedge clk);
    #1;
    bus.btn_up = 0;
    repeat (DB + 8) @(posedge clk);
    @(negedge clk);
    check_all("glitch");
    press(0, 1, 1, 10);
    check_all("up_set");
    chk("up_set_idle", int'(bus.editing), 0);
    for (int i = 0; i < 5; i++) begin
      press(1, 0, 0, 10);
      chk("mode_walk_sel", int'(bus.edit_sel), i < 4 ? 3 - i : 0);
    end
    check_all("mode_walk");
    repeat (4) press(1, 0, 0, 10);
    press(0, 1, 0, 37);
    check_all("hold");
    press(1, 1, 0, 10);
    check_all("up_mode");
    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1: press(1, 0, 0, 10);
        2, 3, 4, 5: press(0, 1, 0, 10);
        6: press(0, 0, 1, 10);
        7: press(1, 1, 0, 10);
        8: press(1, 0, 1, 10);
        default: press(1, 1, 1, 10);
      endcase
      check_all("random");
    end
    while (m_sel != 1) press(1, 0, 0, 10);
    while (m_md != 4) press(0, 1, 0, 10);
    chk("pre_reset_md", int'(bus.mindec_set), 4);
    do_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_all("post_reset");
    chk("load_width", max_run, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/time_setter.md
# time_setter

Button-driven time-entry block that produces the four BCD initial-time digits (hours tens/ones, minutes tens/ones) and a one-cycle load strobe for the watch core. It takes three raw push-buttons, synchronises and debounces them, and steps through a digit-select state machine. Each BCD digit is incremented within the limits of a valid 00:00–23:59 time. It sits between the board buttons and the watch's `*_init` inputs; the strobe drives the watch's reload.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable `clk` samples required before a button level is accepted.
- `REPEAT_DELAY`, 500: hold time in cycles before the first auto-repeat increment (used only with `AUTO_REPEAT_EN`).
- `REPEAT_PERIOD`, 100: cycles between subsequent auto-repeat increments (used only with `AUTO_REPEAT_EN`).
- `clk` in 1: system clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `btn_mode` in 1: raw button, active-high; enters edit and advances the digit.
- `btn_up` in 1: raw button, active-high; increments the selected digit.
- `btn_set` in 1: raw button, active-high; commits and leaves edit.
- `hourdec_set` out 4: hours tens, BCD 0–2.
- `hourone_set` out 4: hours ones, BCD 0–9, limited to 0–3 when `hourdec_set`==2.
- `mindec_set` out 4: minutes tens, BCD 0–5.
- `minone_set` out 4: minutes ones, BCD 0–9.
- `editing` out 1: high while in any EDIT state.
- `edit_sel` out 2: selected digit. 3=HD, 2=HO, 1=MD, 0=MO. 0 in IDLE.
- `load` out 1: one-cycle commit strobe.

## Operation
- Input path per button:
  - 2-FF synchroniser, then a debounce counter. The debounced level changes only after `DEBOUNCE_CYCLES` equal consecutive synchronised samples.
  - A press event is a 1-cycle pulse on the debounced rising edge. Releases generate no event.
- States and transitions:
  - IDLE: mode → EDIT_HD. Up and set are ignored.
  - EDIT_HD: mode → EDIT_HO.
  - EDIT_HO: mode → EDIT_MD.
  - EDIT_MD: mode → EDIT_MO.
  - EDIT_MO: mode → IDLE, with no `load`. Edited digits are retained.
  - Any EDIT state: set → IDLE and `load`=1 for exactly one cycle.
- Increment on an up event, applied to the selected digit only:
  - HD: 0→1→2→0. When HD becomes 2 and HO>3, HO is forced to 3 on the same edge.
  - HO: wraps to 0 after 9, or after 3 when HD==2.
  - MD: wraps to 0 after 5.
  - MO: wraps to 0 after 9.
- Digits never leave their legal ranges. All arithmetic is 4-bit unsigned with no carry into neighbouring digits.
- Simultaneous events in the same cycle:
  - set with anything: set wins; no increment and no advance.
  - up with mode: the increment is applied to the current digit and the state advances on the same edge.
- Outputs are held constant in IDLE. `*_set` reflects the latest values continuously, not only at `load`.

## Timing
- Reset values:
  - Digits 0.
  - State IDLE; `editing`=0, `edit_sel`=0, `load`=0.
  - Synchronisers, debounce counters, debounced levels and the repeat counter are all cleared.
- Reset asserted mid-edit returns to IDLE immediately (asynchronous) with digits 0. No `load` is generated.
- Press latency: a raw level change stable from cycle 0 produces the event pulse at cycle 2+`DEBOUNCE_CYCLES`. The registered outputs (`*_set`, state, `load`) update on the following edge.
- A bounce shorter than `DEBOUNCE_CYCLES` produces no event.
- All outputs are registered, with no combinational path from inputs.
- `load` is high for exactly 1 cycle per commit. It deasserts on the next edge even if `btn_set` is still held.

## Configuration
- `AUTO_REPEAT_EN` defined:
  - While the debounced up level stays high in an EDIT state, one extra increment occurs `REPEAT_DELAY` cycles after the press event.
  - Further increments follow every `REPEAT_PERIOD` cycles.
  - The repeat counter clears on release, on a state change, or in IDLE.
- `AUTO_REPEAT_EN` undefined: exactly one increment per press. Repeat logic and the `REPEAT_*` parameters are unused.

## Test plan
- Reset, then mode, then up ×3 (DEBOUNCE_CYCLES=4) → `hourdec_set` goes 1, 2, 0. After set: one `load` pulse, `editing`=0, `edit_sel`=0.
- In EDIT_HO, up ×9 from 0 → HO reaches 9. Switch to EDIT_HD and press up twice → HD=2 and HO forced to 3. Back in EDIT_HO, up → HO=0.
- EDIT_MD up ×6 → 1, 2, 3, 4, 5, 0. EDIT_MO up ×10 → back to 0. HD/HO/MD unchanged.
- A 2-cycle glitch on `btn_up` with DEBOUNCE_CYCLES=4 → no change. Up and set pulsed together in EDIT_MO → `load`=1, MO unchanged.
- Mode ×5 from IDLE → `edit_sel` 3, 2, 1, 0, then IDLE with `load` never asserted. Reset asserted during EDIT_MD with MD=4 → all digits 0, IDLE.
- With `AUTO_REPEAT_EN` (REPEAT_DELAY=20, REPEAT_PERIOD=5, DEBOUNCE_CYCLES=4), hold up for 40 cycles after debounce in EDIT_MO → MO=6. Without the macro, the same hold → MO=1.
